data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 116 +++++++++++
 tb/tb_data_mem.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// data_mem: byte-addressable data memory with B/H/W/D loads and stores, sign/zero extension,
// and optional split handling of word-crossing accesses behind a valid/ready request/response pair.
module data_mem #(
  parameter int DATA_LEN       = 64,
  parameter int RAM_SIZE       = 12,
  parameter int ADDR_LEN       = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_LEN-1:0] addr_i,
  input  logic [2:0]          memwid_i,
  input  logic [DATA_LEN-1:0] data_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_LEN-1:0] data_o,
  output logic                err_o
);
  localparam int NB    = DATA_LEN / 8;
  localparam int OB    = $clog2(NB);
  localparam int DEPTH = 2 ** RAM_SIZE;
  localparam int AW1   = ADDR_LEN + 1;
  localparam int NB2   = 2 * NB;
  localparam int DW2   = 2 * DATA_LEN;
  localparam logic [ADDR_LEN:0] CAP = AW1'(NB) << RAM_SIZE;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t r_state, w_next;

  logic                r_we;
  logic [ADDR_LEN-1:0] r_addr;
  logic [2:0]          r_wid;
  logic [DATA_LEN-1:0] r_data, r_lo, r_rdata;
  logic                r_err;
  logic [DATA_LEN-1:0] r_mem [DEPTH];

  logic [3:0]          w_size;
  logic [OB-1:0]       w_off;
  logic [RAM_SIZE-1:0] w_idx, w_idx1;
  logic [4:0]          w_end;
  logic                w_cross, w_err;
  logic [ADDR_LEN:0]   w_last;
  logic [NB2-1:0]      w_be;
  logic [DW2-1:0]      w_wd, w_rd2;
  logic [DATA_LEN-1:0] w_raw, w_mask, w_top, w_ext;

  assign w_size  = 4'd1 << r_wid[1:0];
  assign w_off   = r_addr[OB-1:0];
  assign w_idx   = r_addr[OB +: RAM_SIZE];
  assign w_idx1  = w_idx + 1'b1;
  assign w_end   = 5'(w_off) + 5'(w_size);
  assign w_cross = w_end > 5'(NB);
  assign w_last  = AW1'(r_addr) + AW1'(w_size) - 1'b1;
  assign w_err   = r_wid == 3'b111 || (r_wid == 3'b011 && DATA_LEN == 32) || w_last >= CAP ||
                   (w_cross && MISALIGN_SPLIT == 0);

  // Lanes and data span two words so a crossing access is just the upper half of the same vector
  assign w_be  = ((NB2'(1) << w_size) - 1'b1) << w_off;
  assign w_wd  = DW2'(r_data) << {w_off, 3'b000};
  assign w_rd2 = r_state == ACC1 ? {r_mem[w_idx1], r_lo} : DW2'(r_mem[w_idx]);
  assign w_raw = DATA_LEN'(w_rd2 >> {w_off, 3'b000});

  // Mask keeps S bytes; its top bit locates the sign bit for B/H/W
  assign w_mask = ~({DATA_LEN{1'b1}} << {w_size, 3'b000});
  assign w_top  = w_mask ^ (w_mask >> 1);
  assign w_ext  = (w_raw & w_mask) | (!r_wid[2] && |(w_raw & w_top) ? ~w_mask : '0);

  assign req_ready_o  = r_state == IDLE;
  assign resp_valid_o = r_state == RESP;
  assign data_o       = r_rdata;
  assign err_o        = r_err;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (req_valid_i ? ACC0 : IDLE) :
             r_state == ACC0 ? (w_err || !w_cross ? RESP : ACC1) :
             r_state == ACC1 ? RESP : (resp_ready_i ? IDLE : RESP);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wid   <= '0;
      r_data  <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && req_valid_i) begin
        r_we   <= req_we_i;
        r_addr <= addr_i;
        r_wid  <= memwid_i;
        r_data <= data_i;
      end
      if (r_state == ACC0) begin
        r_lo    <= r_mem[w_idx];
        r_err   <= w_err;
        r_rdata <= w_err || r_we || w_cross ? '0 : w_ext;
      end
      if (r_state == ACC1) r_rdata <= r_we ? '0 : w_ext;
    end

  always_ff @(posedge clk)
    for (int b = 0; b < NB; b++) begin
      if (r_state == ACC0 && r_we && !w_err && w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
      if (r_state == ACC1 && r_we && w_be[NB+b]) r_mem[w_idx1][8*b +: 8] <= w_wd[DATA_LEN+8*b +: 8];
    end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed scenarios for data_mem, one instance with split crossing accesses
// and one that rejects them.
module tb_data_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0, vn = 1'b0, we = 1'b0, rr = 1'b1;
  logic [31:0] addr = '0;
  logic [2:0]  wid = '0;
  logic [63:0] din = '0;
  logic        rdy1, rv1, er1, rdy0, rv0, er0;
  logic [63:0] do1, do0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  data_mem #(.MISALIGN_SPLIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vs), .req_ready_o(rdy1), .req_we_i(we),
    .addr_i(addr), .memwid_i(wid), .data_i(din), .resp_valid_o(rv1), .resp_ready_i(rr),
    .data_o(do1), .err_o(er1));

  data_mem #(.MISALIGN_SPLIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vn), .req_ready_o(rdy0), .req_we_i(we),
    .addr_i(addr), .memwid_i(wid), .data_i(din), .resp_valid_o(rv0), .resp_ready_i(rr),
    .data_o(do0), .err_o(er0));

  // sel=1 targets the non-splitting instance; lat counts edges from the handshake edge
  task automatic do_req(input bit sel, input logic w, input logic [31:0] a, input logic [2:0] m,
                        input logic [63:0] d, output logic [63:0] q, output logic e, output int lat);
    @(negedge clk);
    we = w; addr = a; wid = m; din = d;
    if (sel) vn = 1'b1; else vs = 1'b1;
    @(posedge clk); #1;
    vs = 1'b0; vn = 1'b0; lat = 1;
    while (!(sel ? rv0 : rv1) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    q = sel ? do0 : do1;
    e = sel ? er0 : er1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", rdy1); end
    total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", rv1); end
    total++; if (do1 !== 64'h0) begin bad++; $display("FAIL reset_data got %h want 0", do1); end
    total++; if (er1 !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", er1); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_dword;
    logic [63:0] q; logic e; int lat;
    do_req(0, 1, 32'h10, 3'b011, 64'h1122334455667788, q, e, lat);
    total++; if (q !== 64'h0 || e !== 1'b0) begin bad++; $display("FAIL st_d_resp got %h/%b want 0/0", q, e); end
    total++; if (lat !== 2) begin bad++; $display("FAIL st_d_lat got %0d want 2", lat); end
    do_req(0, 0, 32'h10, 3'b011, 64'h0, q, e, lat);
    total++; if (q !== 64'h1122334455667788) begin bad++; $display("FAIL ld_d got %h want 1122334455667788", q); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ld_d_err got %b want 0", e); end
    total++; if (lat !== 2) begin bad++; $display("FAIL ld_d_lat got %0d want 2", lat); end
  endtask

  task automatic test_byte;
    logic [63:0] q; logic e; int lat;
    do_req(0, 1, 32'h13, 3'b000, 64'h80, q, e, lat);
    do_req(0, 0, 32'h13, 3'b000, 64'h0, q, e, lat);
    total++; if (q !== 64'hFFFFFFFFFFFFFF80) begin bad++; $display("FAIL ld_b got %h want ffffffffffffff80", q); end
    do_req(0, 0, 32'h13, 3'b100, 64'h0, q, e, lat);
    total++; if (q !== 64'h80) begin bad++; $display("FAIL ld_bu got %h want 80", q); end
    do_req(0, 0, 32'h10, 3'b011, 64'h0, q, e, lat);
    total++; if (q !== 64'h1122334480667788) begin bad++; $display("FAIL ld_d_after_b got %h want 1122334480667788", q); end
  endtask

  task automatic test_split;
    logic [63:0] q; logic e; int lat;
    do_req(0, 1, 32'h0E, 3'b010, 64'hDEADBEEF, q, e, lat);
    total++; if (lat !== 3 || e !== 1'b0) begin bad++; $display("FAIL st_w_split got lat=%0d err=%b want 3/0", lat, e); end
    do_req(0, 0, 32'h0E, 3'b010, 64'h0, q, e, lat);
    total++; if (q !== 64'hFFFFFFFFDEADBEEF) begin bad++; $display("FAIL ld_w_split got %h want ffffffffdeadbeef", q); end
    total++; if (lat !== 3) begin bad++; $display("FAIL ld_w_split_lat got %0d want 3", lat); end
    do_req(0, 0, 32'h0E, 3'b110, 64'h0, q, e, lat);
    total++; if (q !== 64'h00000000DEADBEEF) begin bad++; $display("FAIL ld_wu_split got %h want deadbeef", q); end
    do_req(0, 0, 32'h10, 3'b011, 64'h0, q, e, lat);
    total++; if (q !== 64'h112233448066DEAD) begin bad++; $display("FAIL ld_d_after_split got %h want 112233448066dead", q); end
    do_req(0, 0, 32'h10, 3'b001, 64'h0, q, e, lat);
    total++; if (q !== 64'hFFFFFFFFFFFFDEAD) begin bad++; $display("FAIL ld_h got %h want ffffffffffffdead", q); end
    do_req(0, 0, 32'h14, 3'b101, 64'h0, q, e, lat);
    total++; if (q !== 64'h3344) begin bad++; $display("FAIL ld_hu got %h want 3344", q); end
  endtask

  task automatic test_errors;
    logic [63:0] q; logic e; int lat;
    do_req(0, 0, 32'h10, 3'b111, 64'h0, q, e, lat);
    total++; if (e !== 1'b1 || q !== 64'h0) begin bad++; $display("FAIL err_wid got %h/%b want 0/1", q, e); end
    total++; if (lat !== 2) begin bad++; $display("FAIL err_wid_lat got %0d want 2", lat); end
    do_req(0, 0, 32'h8000, 3'b011, 64'h0, q, e, lat);
    total++; if (e !== 1'b1 || q !== 64'h0) begin bad++; $display("FAIL err_range got %h/%b want 0/1", q, e); end
    do_req(0, 0, 32'h7FFC, 3'b011, 64'h0, q, e, lat);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL err_range_cross got %b want 1", e); end
    do_req(0, 0, 32'h7FFF, 3'b000, 64'h0, q, e, lat);
    total++; if (e !== 1'b0 || lat !== 2) begin bad++; $display("FAIL last_byte got err=%b lat=%0d want 0/2", e, lat); end
  endtask

  task automatic test_nosplit;
    logic [63:0] q; logic e; int lat;
    do_req(1, 1, 32'h06, 3'b001, 64'hABCD, q, e, lat);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ns_st_h got err=%b want 0", e); end
    do_req(1, 1, 32'h07, 3'b001, 64'h1234, q, e, lat);
    total++; if (e !== 1'b1 || q !== 64'h0) begin bad++; $display("FAIL ns_cross got %h/%b want 0/1", q, e); end
    do_req(1, 0, 32'h07, 3'b100, 64'h0, q, e, lat);
    total++; if (q !== 64'hAB) begin bad++; $display("FAIL ns_unchanged got %h want ab", q); end
    do_req(1, 0, 32'h06, 3'b001, 64'h0, q, e, lat);
    total++; if (q !== 64'hFFFFFFFFFFFFABCD) begin bad++; $display("FAIL ns_ld_h got %h want ffffffffffffabcd", q); end
  endtask

  task automatic test_hold;
    logic [63:0] q; logic e; int lat;
    rr = 1'b0;
    @(negedge clk);
    we = 1'b0; addr = 32'h10; wid = 3'b011; din = '0; vs = 1'b1;
    @(posedge clk); #1;
    vs = 1'b0; lat = 1;
    while (!rv1 && lat < 10) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 2) begin bad++; $display("FAIL hold_lat got %0d want 2", lat); end
    we = 1'b1; din = 64'h0; vs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (rv1 !== 1'b1 || do1 !== 64'h112233448066DEAD || er1 !== 1'b0 || rdy1 !== 1'b0) begin
        bad++; $display("FAIL hold_%0d got v=%b d=%h e=%b r=%b want 1/112233448066dead/0/0", i, rv1, do1, er1, rdy1);
      end
    end
    vs = 1'b0; rr = 1'b1;
    @(posedge clk); #1;
    total++; if (rdy1 !== 1'b1 || rv1 !== 1'b0) begin bad++; $display("FAIL hold_release got r=%b v=%b want 1/0", rdy1, rv1); end
    do_req(0, 0, 32'h10, 3'b011, 64'h0, q, e, lat);
    total++; if (q !== 64'h112233448066DEAD) begin bad++; $display("FAIL hold_ignored got %h want 112233448066dead", q); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] q; logic e; int lat;
    do_req(0, 1, 32'h20, 3'b001, 64'h5566, q, e, lat);
    @(negedge clk);
    we = 1'b1; addr = 32'h1E; wid = 3'b010; din = 64'h01020304; vs = 1'b1;
    @(posedge clk); #1;
    vs = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (rv1 !== 1'b0 || rdy1 !== 1'b1 || do1 !== 64'h0) begin bad++; $display("FAIL mid_reset got v=%b r=%b d=%h want 0/1/0", rv1, rdy1, do1); end
    @(negedge clk) rst_n = 1'b1;
    do_req(0, 0, 32'h1E, 3'b101, 64'h0, q, e, lat);
    total++; if (q !== 64'h0304) begin bad++; $display("FAIL mid_low_written got %h want 0304", q); end
    do_req(0, 0, 32'h20, 3'b101, 64'h0, q, e, lat);
    total++; if (q !== 64'h5566) begin bad++; $display("FAIL mid_high_untouched got %h want 5566", q); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_dword;
    test_byte;
    test_split;
    test_errors;
    test_nosplit;
    test_hold;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
